// File: rtl/addr_range_match_if.sv
// Bundles the config port, request stream and result stream of addr_range_match_pipe.
// 'master' is the host side; 'slave' is the classifier.
interface addr_range_match_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int FLAG_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int RULE_IDX_W = 5,
  parameter int CFG_WIDTH  = 10
);
  logic [CFG_WIDTH-1:0]  cfg_address;
  logic                  cfg_write;
  logic [63:0]           cfg_writedata;
  logic [7:0]            cfg_byteenable;
  logic                  cfg_read;
  logic [63:0]           cfg_readdata;

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [TAG_WIDTH-1:0]  in_tag;

  logic                  out_valid;
  logic                  out_ready;
  logic                  out_hit;
  logic [RULE_IDX_W-1:0] out_index;
  logic [FLAG_WIDTH-1:0] out_flags;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [TAG_WIDTH-1:0]  out_tag;

  modport master (
    output cfg_address, cfg_write, cfg_writedata, cfg_byteenable, cfg_read,
    output in_valid, in_addr, in_tag, out_ready,
    input  cfg_readdata, in_ready,
    input  out_valid, out_hit, out_index, out_flags, out_addr, out_tag
  );

  modport slave (
    input  cfg_address, cfg_write, cfg_writedata, cfg_byteenable, cfg_read,
    input  in_valid, in_addr, in_tag, out_ready,
    output cfg_readdata, in_ready,
    output out_valid, out_hit, out_index, out_flags, out_addr, out_tag
  );
endinterface

// File: rtl/addr_range_match_pipe.sv
// Programmable address-range classifier: 3-stage back-pressured pipeline
// (register request, per-rule compare, merge) with a 64-bit byte-enabled config port.
module addr_range_match_pipe #(
  parameter int NUM_RULES  = 32,
  parameter int RULE_IDX_W = 5,
  parameter int ADDR_WIDTH = 64,
  parameter int FLAG_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int CFG_WIDTH  = 10
) (
  input  logic               clk,
  input  logic               reset,
  addr_range_match_if.slave  bus,
  output logic [63:0]        dsm_base
);

  localparam logic [CFG_WIDTH-1:0] A_DSM  = CFG_WIDTH'(3 * NUM_RULES);
  localparam logic [CFG_WIDTH-1:0] A_CTRL = CFG_WIDTH'(3 * NUM_RULES + 1);
  localparam logic [CFG_WIDTH-1:0] A_DEF  = CFG_WIDTH'(3 * NUM_RULES + 2);
  localparam logic [CFG_WIDTH-1:0] A_HIT  = CFG_WIDTH'(3 * NUM_RULES + 3);
  localparam logic [CFG_WIDTH-1:0] A_MISS = CFG_WIDTH'(3 * NUM_RULES + 4);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0]   limit_t;
  typedef logic [FLAG_WIDTH-1:0] flags_t;

  addr_t                rule_base  [NUM_RULES];
  addr_t                rule_size  [NUM_RULES];
  limit_t               rule_limit [NUM_RULES];
  flags_t               rule_flags [NUM_RULES];
  logic [NUM_RULES-1:0] rule_en;
  logic                 mode;
  flags_t               default_flags;
  logic [31:0]          hit_count;
  logic [31:0]          miss_count;

  function automatic logic [63:0] be_merge(input logic [63:0] old_val,
                                           input logic [63:0] new_val,
                                           input logic [7:0]  be);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++)
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    return res;
  endfunction

  // ---------------------------------------------------------------- config decode
  logic [NUM_RULES-1:0] wr_base, wr_size, wr_flags;
  logic                 wr_dsm, wr_ctrl, wr_def, clr_hit, clr_miss;
  logic [63:0]          wd;
  logic [7:0]           be;

  assign wd = bus.cfg_writedata;
  assign be = bus.cfg_byteenable;

  always_comb begin
    wr_base  = '0;
    wr_size  = '0;
    wr_flags = '0;
    for (int r = 0; r < NUM_RULES; r++) begin
      wr_base[r]  = bus.cfg_write && (bus.cfg_address == CFG_WIDTH'(r));
      wr_size[r]  = bus.cfg_write && (bus.cfg_address == CFG_WIDTH'(NUM_RULES + r));
      wr_flags[r] = bus.cfg_write && (bus.cfg_address == CFG_WIDTH'(2 * NUM_RULES + r));
    end
    wr_dsm   = bus.cfg_write && (bus.cfg_address == A_DSM);
    wr_ctrl  = bus.cfg_write && (bus.cfg_address == A_CTRL);
    wr_def   = bus.cfg_write && (bus.cfg_address == A_DEF);
    clr_hit  = bus.cfg_write && (bus.cfg_address == A_HIT)  && (|be);
    clr_miss = bus.cfg_write && (bus.cfg_address == A_MISS) && (|be);
  end

  // NOTE: rule base/size/flag data is plain storage with no reset; clearing the
  // enable bits is what keeps stale entries from matching after reset.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_RULES; r++) begin
      if (wr_base[r])  rule_base[r]  <= addr_t'(be_merge(64'(rule_base[r]), wd, be));
      if (wr_size[r])  rule_size[r]  <= addr_t'(be_merge(64'(rule_size[r]), wd, be));
      if (wr_flags[r]) rule_flags[r] <= flags_t'(be_merge(64'(rule_flags[r]), wd, be));
      // Recomputed every cycle, so it trails any base/size write by exactly one cycle.
      rule_limit[r] <= limit_t'(rule_base[r]) + limit_t'(rule_size[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rule_en       <= '0;
      mode          <= 1'b0;
      default_flags <= '0;
      dsm_base      <= '0;
    end else begin
      for (int r = 0; r < NUM_RULES; r++)
        if (wr_flags[r] && be[7]) rule_en[r] <= wd[63];
      if (wr_ctrl && be[0]) mode <= wd[0];
      if (wr_def) default_flags <= flags_t'(be_merge(64'(default_flags), wd, be));
      if (wr_dsm) dsm_base <= be_merge(dsm_base, wd, be);
    end
  end

  logic [63:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int r = 0; r < NUM_RULES; r++) begin
      if (bus.cfg_address == CFG_WIDTH'(r))             rd_mux = 64'(rule_base[r]);
      if (bus.cfg_address == CFG_WIDTH'(NUM_RULES + r)) rd_mux = 64'(rule_size[r]);
      if (bus.cfg_address == CFG_WIDTH'(2 * NUM_RULES + r))
        rd_mux = {rule_en[r], 63'(rule_flags[r])};
    end
    if (bus.cfg_address == A_DSM)  rd_mux = dsm_base;
    if (bus.cfg_address == A_CTRL) rd_mux = {63'b0, mode};
    if (bus.cfg_address == A_DEF)  rd_mux = 64'(default_flags);
    if (bus.cfg_address == A_HIT)  rd_mux = {32'b0, hit_count};
    if (bus.cfg_address == A_MISS) rd_mux = {32'b0, miss_count};
  end

  always_ff @(posedge clk) begin
    if (reset)             bus.cfg_readdata <= '0;
    else if (bus.cfg_read) bus.cfg_readdata <= rd_mux;
  end

  // ---------------------------------------------------------------- pipeline
  logic                 advance;
  logic                 s1_valid, s2_valid;
  addr_t                s1_addr, s2_addr;
  logic [TAG_WIDTH-1:0] s1_tag, s2_tag;
  logic [NUM_RULES-1:0] s2_match, match_c;

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  always_comb begin
    match_c = '0;
    for (int r = 0; r < NUM_RULES; r++)
      match_c[r] = rule_en[r] && (rule_size[r] != '0) &&
                   (s1_addr >= rule_base[r]) && ({1'b0, s1_addr} < rule_limit[r]);
  end

  logic                  hit_c;
  logic [RULE_IDX_W-1:0] idx_c;
  flags_t                or_flags_c, pri_flags_c, flags_c;

  always_comb begin
    hit_c       = |s2_match;
    idx_c       = '0;
    or_flags_c  = '0;
    pri_flags_c = '0;
    // Walking downward leaves the lowest matching rule in idx_c/pri_flags_c.
    for (int r = NUM_RULES - 1; r >= 0; r--) begin
      if (s2_match[r]) begin
        idx_c       = RULE_IDX_W'(r);
        pri_flags_c = rule_flags[r];
        or_flags_c  = or_flags_c | rule_flags[r];
      end
    end
    if (!hit_c)    flags_c = default_flags;
    else if (mode) flags_c = pri_flags_c;
    else           flags_c = or_flags_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (advance) begin
      s1_valid      <= bus.in_valid;
      s2_valid      <= s1_valid;
      bus.out_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_addr       <= bus.in_addr;
      s1_tag        <= bus.in_tag;
      s2_addr       <= s1_addr;
      s2_tag        <= s1_tag;
      s2_match      <= match_c;
      bus.out_hit   <= hit_c;
      bus.out_index <= idx_c;
      bus.out_flags <= flags_c;
      bus.out_addr  <= s2_addr;
      bus.out_tag   <= s2_tag;
    end
  end

  // ---------------------------------------------------------------- counters
  logic out_fire;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      // NOTE: the clear is tested first so a same-cycle increment cannot override it.
      if (clr_hit)
        hit_count <= '0;
      else if (out_fire && bus.out_hit && (hit_count != '1))
        hit_count <= hit_count + 32'd1;
      if (clr_miss)
        miss_count <= '0;
      else if (out_fire && !bus.out_hit && (miss_count != '1))
        miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: doc/addr_range_match_pipe.md
# addr_range_match_pipe

Parametrised, back-pressured address-range classifier that succeeds the fixed 32-rule range comparator. Software programs up to NUM_RULES base/size/flag rules plus DSM base, mode and default-flag registers through a 64-bit byte-enabled config port. Each request address is classified in a 3-stage pipeline and returns hit, matching rule index and flags, either OR-merged or lowest-index priority. Hit/miss counters are readable. It sits between the host-request decode and the CCI request path.

## Interface
- NUM_RULES, 32, number of rules (1..64)
- RULE_IDX_W, 5, clog2(NUM_RULES), min 1
- ADDR_WIDTH, 64, request address width (≤64)
- FLAG_WIDTH, 32, flag bits per rule (≤62)
- TAG_WIDTH, 8, opaque sideband carried with each request
- CFG_WIDTH, 10, config word address width; must cover 3*NUM_RULES+5 words
- clk  in  1  sole clock; all logic is on posedge clk
- reset  in  1  synchronous, active-high
- cfg_address  in  CFG_WIDTH  64-bit word index
- cfg_write  in  1  write strobe
- cfg_writedata  in  64  write data
- cfg_byteenable  in  8  per-byte write enable
- cfg_read  in  1  read strobe
- cfg_readdata  out  64  read data, 1 cycle after cfg_read
- in_valid / in_ready  in/out  1  request handshake
- in_addr  in  ADDR_WIDTH  request address
- in_tag  in  TAG_WIDTH  request sideband
- out_valid / out_ready  out/in  1  result handshake
- out_hit  out  1  at least one enabled rule matched
- out_index  out  RULE_IDX_W  lowest matching rule index; 0 on miss
- out_flags  out  FLAG_WIDTH  result flags
- out_addr, out_tag  out  ADDR_WIDTH, TAG_WIDTH  request echo
- dsm_base  out  64  DSM base register

## Operation
- Register map (word index): r in 0..N-1 holds base[r]. N+r holds size[r]. 2N+r holds flags[r]: bit 63 enables the rule, bits FLAG_WIDTH-1:0 are the flags. 3N is dsm_base. 3N+1 is ctrl: bit0 mode, 0 = OR-merge, 1 = priority. 3N+2 holds the default flags used on a miss. 3N+3 is hit_count and 3N+4 is miss_count, each 32 bits in [31:0] with upper bits reading 0.
- Writes honour byteenable per byte. A write of any byte to a counter address clears that counter. Writes to unmapped addresses are ignored. Reads of unmapped addresses return 0.
- Match for rule r requires enable[r] && size[r]!=0 && in_addr ≥ base[r] && in_addr < base[r]+size[r].
  - The sum is computed at ADDR_WIDTH+1 bits, so a range never wraps past the top of the address space.
  - base and size use the low ADDR_WIDTH bits only.
- Rule limit max[r] is a register updated the cycle after any write touching base[r] or size[r].
- Mode 0: out_flags is the OR of flags over all matching rules.
- Mode 1: out_flags is the flags of the lowest-index matching rule.
- out_index is always the lowest matching index, in both modes.
- On a miss: out_hit=0, out_index=0, out_flags = default flags.
- Counters: on each out_valid && out_ready, hit_count increments if out_hit, otherwise miss_count increments. Both saturate at 0xFFFF_FFFF. If a clear and an increment land in the same cycle, the clear wins and the counter reads 0.
- Reset values:
  - Cleared: all enable bits, ctrl, default flags, dsm_base, both counters, all pipeline valids, out_valid, cfg_readdata.
  - Not reset: base, size, flag data bits.

## Timing
- Pipeline: S1 registers the request, S2 computes the per-rule match vector, S3 merges and drives the outputs.
- Latency is 3 cycles from accepted in_valid to out_valid while out_ready is held high.
- advance = !out_valid || out_ready. in_ready = advance.
- All stages shift only on advance. Bubbles are not collapsed.
- out_* hold stable while out_valid && !out_ready.
- Throughput is 1 request per cycle.
- Config coherence:
  - A rule write in cycle W is fully visible to requests whose S2 compare occurs in cycle W+2 or later.
  - Earlier in-flight requests may see old or mixed values. Software quiesces traffic before reprogramming.
- dsm_base updates the cycle after its write.
- cfg_readdata is valid exactly 1 cycle after cfg_read and holds until the next read.
- Reset asserted mid-operation drops all in-flight requests. out_valid is 0 the cycle after reset is sampled.

## Test plan
- Single rule: base 0x1000, size 0x100, flags 0x5, enabled. Send 0x0FFF, 0x1000, 0x10FF, 0x1100. Expect hit pattern 0,1,1,0, with out_flags 0x5 on hits and the default flags on misses, each result 3 cycles after acceptance.
- Overlap: rule 2 (0x0–0x1FFF, flags 0x1) and rule 7 (0x1000–0x17FF, flags 0x2). Addr 0x1200 gives mode 0 → flags 0x3, index 2; mode 1 → flags 0x1, index 2.
- Boundary: base 0xFFFF_FFFF_FFFF_FF00 with size 0x200 matches 0xFFFF_FFFF_FFFF_FFFF. A size-0 rule and a disabled rule never match.
- Backpressure: stream 10 requests with out_ready toggling in a random pattern. Every result arrives in order with the correct tag, outputs stay stable while stalled, and the counters total 10.
- Counters: force miss_count to 0xFFFF_FFFF and send a miss; it stays saturated. A clear write in the same cycle as a hit transfer leaves hit_count at 0.
- Reset mid-stream: assert reset with 3 requests in flight. Expect out_valid=0 and counters 0 the next cycle, and all rule enables cleared.
